// File: rtl/reg_file_sync.sv
// Parametrised two-read/one-write register file with registered, flagged read data.
// Define REGFILE_BYPASS_EN for write-first collisions; otherwise collisions read first.
module reg_file_sync #(
  parameter int unsigned DATA_W   = 8,
  parameter int unsigned ADDR_W   = 3,
  parameter int unsigned ZERO_REG = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr_1,
  input  logic [ADDR_W-1:0] rd_addr_2,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic [DATA_W-1:0] rd_data_1,
  output logic [DATA_W-1:0] rd_data_2,
  output logic              rd_valid
);

  localparam int unsigned DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] mem_d [DEPTH];
  logic [DATA_W-1:0] rd_data_1_q, rd_data_1_d;
  logic [DATA_W-1:0] rd_data_2_q, rd_data_2_d;
  logic              rd_valid_q, rd_valid_d;
  logic              wr_ok;
  logic [DATA_W-1:0] rd_val_1, rd_val_2;

  always_comb begin
    mem_d = mem_q;
    wr_ok = wr_en && !((ZERO_REG != 0) && (wr_addr == '0));
    if (wr_ok) begin
      mem_d[wr_addr] = wr_data;
    end

    rd_val_1 = mem_q[rd_addr_1];
    rd_val_2 = mem_q[rd_addr_2];
`ifdef REGFILE_BYPASS_EN
    // wr_ok already excludes the hardwired entry, so the zero override below still wins
    if (wr_ok && (wr_addr == rd_addr_1)) rd_val_1 = wr_data;
    if (wr_ok && (wr_addr == rd_addr_2)) rd_val_2 = wr_data;
`endif
    if ((ZERO_REG != 0) && (rd_addr_1 == '0)) rd_val_1 = '0;
    if ((ZERO_REG != 0) && (rd_addr_2 == '0)) rd_val_2 = '0;

    rd_valid_d  = rd_en;
    rd_data_1_d = rd_en ? rd_val_1 : rd_data_1_q;
    rd_data_2_d = rd_en ? rd_val_2 : rd_data_2_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      rd_data_1_q <= '0;
      rd_data_2_q <= '0;
      rd_valid_q  <= 1'b0;
    end else begin
      mem_q       <= mem_d;
      rd_data_1_q <= rd_data_1_d;
      rd_data_2_q <= rd_data_2_d;
      rd_valid_q  <= rd_valid_d;
    end
  end

  assign rd_data_1 = rd_data_1_q;
  assign rd_data_2 = rd_data_2_q;
  assign rd_valid  = rd_valid_q;

endmodule

// File: tb/tb_reg_file_sync.sv
// Directed bench for reg_file_sync: default, ZERO_REG=0 and 32x32 instances.
module tb_reg_file_sync;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, rd_en, wr_en;
  logic [2:0] a1, a2, wa;
  logic [7:0] wd;
  logic [7:0] z_d1, z_d2, n_d1, n_d2;
  logic       z_v, n_v;

  logic        w_rd_en, w_wr_en;
  logic [4:0]  w_a1, w_a2, w_wa;
  logic [31:0] w_wd, w_d1, w_d2;
  logic        w_v;

  int checks = 0;
  int errors = 0;

  reg_file_sync #(.DATA_W(8), .ADDR_W(3), .ZERO_REG(1)) u_zero (
    .clk(clk), .rst(rst), .rd_en(rd_en), .rd_addr_1(a1), .rd_addr_2(a2),
    .wr_en(wr_en), .wr_addr(wa), .wr_data(wd),
    .rd_data_1(z_d1), .rd_data_2(z_d2), .rd_valid(z_v)
  );

  reg_file_sync #(.DATA_W(8), .ADDR_W(3), .ZERO_REG(0)) u_norm (
    .clk(clk), .rst(rst), .rd_en(rd_en), .rd_addr_1(a1), .rd_addr_2(a2),
    .wr_en(wr_en), .wr_addr(wa), .wr_data(wd),
    .rd_data_1(n_d1), .rd_data_2(n_d2), .rd_valid(n_v)
  );

  reg_file_sync #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(1)) u_wide (
    .clk(clk), .rst(rst), .rd_en(w_rd_en), .rd_addr_1(w_a1), .rd_addr_2(w_a2),
    .wr_en(w_wr_en), .wr_addr(w_wa), .wr_data(w_wd),
    .rd_data_1(w_d1), .rd_data_2(w_d2), .rd_valid(w_v)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    rd_en = 1'b0; wr_en = 1'b0;
  endtask

  task automatic wr(input logic [2:0] addr, input logic [7:0] data);
    wr_en = 1'b1; wa = addr; wd = data; rd_en = 1'b0;
    tick();
    wr_en = 1'b0;
  endtask

  logic [7:0] exp_b, exp_z0, exp_n;

  initial begin
    rst = 1'b1; rd_en = 1'b0; wr_en = 1'b0; a1 = '0; a2 = '0; wa = '0; wd = '0;
    w_rd_en = 1'b0; w_wr_en = 1'b0; w_a1 = '0; w_a2 = '0; w_wa = '0; w_wd = '0;
    tick();
    check("rst_valid", {31'd0, z_v}, 32'd0);
    check("rst_d1", {24'd0, z_d1}, 32'd0);
    check("rst_d2", {24'd0, z_d2}, 32'd0);
    check("rst_wide_valid", {31'd0, w_v}, 32'd0);
    check("rst_wide_d1", w_d1, 32'd0);
    rst = 1'b0;

    // basic write then read
    wr(3'd3, 8'hA5);
    wr(3'd7, 8'h3C);
    rd_en = 1'b1; a1 = 3'd3; a2 = 3'd7;
    tick();
    check("rd_d1", {24'd0, z_d1}, 32'hA5);
    check("rd_d2", {24'd0, z_d2}, 32'h3C);
    check("rd_valid", {31'd0, z_v}, 32'd1);
    idle();
    tick();
    check("idle_valid", {31'd0, z_v}, 32'd0);
    check("hold_d1", {24'd0, z_d1}, 32'hA5);
    check("hold_d2", {24'd0, z_d2}, 32'h3C);

    // zero register
    wr(3'd0, 8'hFF);
    rd_en = 1'b1; a1 = 3'd0; a2 = 3'd0;
    tick();
    check("zero_d1", {24'd0, z_d1}, 32'h00);
    check("zero_d2", {24'd0, z_d2}, 32'h00);
    check("nozero_d1", {24'd0, n_d1}, 32'hFF);
    check("nozero_d2", {24'd0, n_d2}, 32'hFF);
    check("nozero_valid", {31'd0, n_v}, 32'd1);
    idle();

    // same-edge write/read collision
    wr(3'd5, 8'h11);
    tick();
`ifdef REGFILE_BYPASS_EN
    exp_b = 8'h22; exp_z0 = 8'h00; exp_n = 8'h77;
`else
    exp_b = 8'h11; exp_z0 = 8'h00; exp_n = 8'hFF;
`endif
    wr_en = 1'b1; wa = 3'd5; wd = 8'h22; rd_en = 1'b1; a1 = 3'd5; a2 = 3'd3;
    tick();
    check("coll_d1", {24'd0, z_d1}, {24'd0, exp_b});
    check("coll_other_port", {24'd0, z_d2}, 32'hA5);
    wr_en = 1'b0; a1 = 3'd5; a2 = 3'd5;
    tick();
    check("after_coll_d1", {24'd0, z_d1}, 32'h22);
    check("after_coll_d2", {24'd0, z_d2}, 32'h22);
    wr_en = 1'b1; wa = 3'd0; wd = 8'h77; a1 = 3'd0; a2 = 3'd0;
    tick();
    check("coll_zero_z", {24'd0, z_d1}, {24'd0, exp_z0});
    check("coll_zero_n", {24'd0, n_d2}, {24'd0, exp_n});
    idle();

    // reset mid-operation
    for (int i = 1; i < 8; i++) wr(3'(i), 8'(i));
    rst = 1'b1; rd_en = 1'b1; a1 = 3'd4; a2 = 3'd4;
    tick();
    check("midrst_valid", {31'd0, z_v}, 32'd0);
    check("midrst_d1", {24'd0, z_d1}, 32'd0);
    check("midrst_d2", {24'd0, z_d2}, 32'd0);
    rst = 1'b0; a1 = 3'd0; a2 = 3'd7;
    tick();
    check("postrst_valid", {31'd0, z_v}, 32'd1);
    check("postrst_n_d1", {24'd0, n_d1}, 32'd0);
    check("postrst_z_d2", {24'd0, z_d2}, 32'd0);
    idle();

    // streaming reads
    for (int i = 0; i < 8; i++) wr(3'(i), 8'h10 + 8'(i));
    for (int i = 0; i < 8; i++) begin
      rd_en = 1'b1; a1 = 3'(i); a2 = 3'(7 - i);
      tick();
      check("stream_valid", {31'd0, z_v}, 32'd1);
      check("stream_z_d1", {24'd0, z_d1}, (i == 0) ? 32'h00 : 32'h10 + i);
      check("stream_z_d2", {24'd0, z_d2}, (i == 7) ? 32'h00 : 32'h10 + (7 - i));
      check("stream_n_d1", {24'd0, n_d1}, 32'h10 + i);
    end
    idle();
    tick();
    check("stream_end_valid", {31'd0, z_v}, 32'd0);

    // wide instance
    w_wr_en = 1'b1; w_wa = 5'd15; w_wd = 32'h0BADF00D;
    tick();
    w_wa = 5'd31; w_wd = 32'hDEADBEEF;
    tick();
    w_wr_en = 1'b0; w_rd_en = 1'b1; w_a1 = 5'd31; w_a2 = 5'd15;
    tick();
    check("wide_d1", w_d1, 32'hDEADBEEF);
    check("wide_d2", w_d2, 32'h0BADF00D);
    check("wide_valid", {31'd0, w_v}, 32'd1);
    w_rd_en = 1'b0;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/reg_file_sync.md
Name: reg_file_sync

Overview:
- Parametrised successor of the 8x8 two-read/one-write register file used by the single-cycle datapath.
- Width and depth are configurable.
- Writes and reads are fully synchronous; read data is registered with a valid flag.
- Synchronous clear of all entries; the register 0 hardwire is selectable by parameter.
- Sits between the decode stage (read addresses) and write-back (write port) of the MIPS-style core.

Parameters:
DATA_W, 8, bit width of each register
ADDR_W, 3, address width; register count DEPTH = 2**ADDR_W
ZERO_REG, 1, 1 = entry 0 reads as 0 and ignores writes; 0 = entry 0 is a normal register

Ports:
clk  input  1  clock; all state changes on rising edge
rst  input  1  synchronous reset, active-high
rd_en  input  1  read request; samples both read addresses this cycle
rd_addr_1  input  ADDR_W  read port 1 address
rd_addr_2  input  ADDR_W  read port 2 address
wr_en  input  1  write request
wr_addr  input  ADDR_W  write address
wr_data  input  DATA_W  write data
rd_data_1  output  DATA_W  registered read data, port 1
rd_data_2  output  DATA_W  registered read data, port 2
rd_valid  output  1  high for exactly the cycle after an accepted rd_en

Behaviour:
- Reset:
  - On a rising edge with rst=1, all DEPTH entries are cleared to 0.
  - rd_data_1, rd_data_2 and rd_valid are cleared to 0.
  - rd_en and wr_en are ignored that cycle; rst has priority over every other input.
  - Reset asserted mid-stream: any pending read result is discarded, so rd_valid=0 on the next cycle.
- Write:
  - On an edge with wr_en=1 and rst=0, entry[wr_addr] <= wr_data.
  - With ZERO_REG=1 and wr_addr=0, the write is dropped and entry 0 stays 0.
- Read:
  - On an edge with rd_en=1 and rst=0, rd_data_1 <= value(rd_addr_1) and rd_data_2 <= value(rd_addr_2), and rd_valid <= 1. Read latency is 1 cycle.
  - On an edge with rd_en=0, rd_valid <= 0 and rd_data_1/rd_data_2 hold their previous values.
- value(a) is the stored entry[a], except in these cases:
  - ZERO_REG=1 and a=0: value is 0 regardless of storage.
  - Same-edge write to the same address (wr_en=1, wr_addr=a): see Optional Feature.
- Both read ports may address the same entry; each gets the same value.
- Back-to-back reads every cycle are supported (throughput 1 read pair per cycle), and rd_valid stays high continuously.
- A simultaneous write plus two reads in one cycle is always legal.
- No internal state machine beyond the storage array and the output registers; there are no stall or backpressure signals.
- Widths are exact: no truncation or extension inside the block. Out-of-range addresses cannot occur because DEPTH = 2**ADDR_W.

Optional Feature:
- Macro: REGFILE_BYPASS_EN
- Defined (write-first): when wr_en=1 and wr_addr equals a read address on the same edge as rd_en=1, that port's rd_data takes wr_data. The only exception is ZERO_REG=1 with address 0, where the port still returns 0.
- Undefined (read-first): the same collision returns the old stored value. The new value is visible to reads issued on the following edge onward.
- The write to storage happens identically in both builds.

Test Plan:
- Reset, write, read: assert rst 1 cycle. Then write 0xA5 to addr 3 and 0x3C to addr 7. Then rd_en with rd_addr_1=3, rd_addr_2=7 -> next cycle rd_data_1=0xA5, rd_data_2=0x3C, rd_valid=1. One cycle later with rd_en=0: rd_valid=0 and the data holds.
- Zero register (ZERO_REG=1): write 0xFF to addr 0, then read addr 0 on both ports -> both 0x00. With ZERO_REG=0 the same sequence returns 0xFF.
- Collision: write 0x11 to addr 5 and idle. Then on one edge write 0x22 to addr 5 with rd_en, rd_addr_1=5 -> rd_data_1=0x22 with REGFILE_BYPASS_EN defined, 0x11 without it. A read of addr 5 on the next edge returns 0x22 in both builds.
- Reset mid-operation: fill addrs 1..7 with values 1..7. Assert rst on the same edge as rd_en for addr 4 -> rd_valid=0, rd_data=0. A subsequent read of any address returns 0.
- Streaming: rd_en held high for 8 cycles reading addr i on port 1 and addr 7-i on port 2 -> rd_valid high for 8 consecutive cycles, with data matching the contents at one cycle of latency.
- Parameter sweep: DATA_W=32, ADDR_W=5. Write 0xDEADBEEF to addr 31 and read it back -> 0xDEADBEEF, with no effect on addr 15.
